// File: rtl/mprj_wb_responder_if.sv
// Wishbone bus bundle between the mgmt-core master
// and the user-project responder.
interface mprj_wb_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mprj_wb_responder.sv
// Wishbone responder: 8 RW regs, ID, cycle counter,
// programmable ack wait states and a level IRQ.
module mprj_wb_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter logic [31:0] ID_VALUE  = 32'h4653_4943,
  parameter logic [3:0]  WAIT_RST  = 4'd0
) (
  input  logic core_clk,
  input  logic core_rstn,
  mprj_wb_responder_if.slave wb,
  output logic irq_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t      state, nxt;
  logic [31:0] regs [8];
  logic [31:0] cnt;
  logic [3:0]  wait_r;
  logic        irq_r;
  logic [3:0]  wcnt;
  logic [5:0]  off_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [31:0] rdata_q;

  logic        req, hit, in_idle, enter_ack;
  logic [5:0]  e_off;
  logic        e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_dat;
  logic [31:0] rd_mux;

  assign req = wb.wbs_cyc_i & wb.wbs_stb_i;
  assign hit = req &
    ((wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign in_idle = (state == IDLE);

  // First access is served straight from the bus;
  // waited accesses use the fields latched in IDLE.
  assign e_off = in_idle ? wb.wbs_adr_i[7:2] : off_q;
  assign e_we  = in_idle ? wb.wbs_we_i : we_q;
  assign e_sel = in_idle ? wb.wbs_sel_i : sel_q;
  assign e_dat = in_idle ? wb.wbs_dat_i : dat_q;
  assign enter_ack = (nxt == ACK);

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] val,
    input logic [3:0]  sel
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = val[8*b +: 8];
    return res;
  endfunction

  // State register
  always_ff @(posedge core_clk) begin
    if (!core_rstn) state <= IDLE;
    else            state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (hit)
          nxt = (wait_r == 4'd0) ? ACK : WAITS;
      WAITS:
        if (!req)              nxt = IDLE;
        else if (wcnt == 4'd1) nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Bus outputs: data only qualified by ack
  always_comb begin
    wb.wbs_ack_o = (state == ACK);
    wb.wbs_dat_o = (state == ACK) ? rdata_q : 32'd0;
  end

  // Request capture and wait-state countdown
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      off_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      wcnt  <= '0;
    end else if (in_idle && hit) begin
      off_q <= wb.wbs_adr_i[7:2];
      we_q  <= wb.wbs_we_i;
      sel_q <= wb.wbs_sel_i;
      dat_q <= wb.wbs_dat_i;
      wcnt  <= wait_r;
    end else if (state == WAITS) begin
      wcnt  <= wcnt - 4'd1;
    end
  end

  // Read decode
  always_comb begin
    rd_mux = 32'd0;
    unique case (1'b1)
      (e_off[5:3] == 3'd0): rd_mux = regs[e_off[2:0]];
      (e_off == 6'h08):     rd_mux = ID_VALUE;
      (e_off == 6'h09):     rd_mux = cnt;
      (e_off == 6'h0A):     rd_mux = {28'd0, wait_r};
      (e_off == 6'h0B):     rd_mux = {31'd0, irq_r};
      default:              rd_mux = 32'd0;
    endcase
  end

  // Register file, counter, and read-data capture
  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      cnt     <= '0;
      wait_r  <= WAIT_RST;
      irq_r   <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt <= cnt + 32'd1;
      if (enter_ack) begin
        rdata_q <= rd_mux;
        if (e_we) begin
          unique case (1'b1)
            (e_off[5:3] == 3'd0):
              regs[e_off[2:0]] <=
                merge(regs[e_off[2:0]], e_dat, e_sel);
            (e_off == 6'h0A):
              if (e_sel[0]) wait_r <= e_dat[3:0];
            (e_off == 6'h0B):
              if (e_sel[0]) irq_r <= e_dat[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign irq_o = irq_r;

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Directed bench for mprj_wb_responder: timing,
// byte masking, aborts, counter wrap and reset.
module tb_mprj_wb_responder;
  logic clk = 1'b0;
  logic rstn;
  logic irq;
  int   nvec = 0;
  int   nerr = 0;

  mprj_wb_responder_if wb();

  mprj_wb_responder dut (
    .core_clk  (clk),
    .core_rstn (rstn),
    .wb        (wb),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit we,
                      input logic [31:0] adr,
                      input logic [3:0] sel,
                      input logic [31:0] dat,
                      output logic [31:0] rd,
                      output int cyc_n,
                      output bit acked);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_sel_i = sel;
    wb.wbs_dat_i = dat;
    acked = 1'b0;
    cyc_n = 0;
    rd    = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cyc_n++;
      if (wb.wbs_ack_o) begin
        acked = 1'b1;
        rd = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, rd2;
    int n;
    bit ak;
    int seen;

    rstn = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = '0;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rstn = 1'b1;

    xfer(0, 32'h3000_0020, 4'hF, 0, rd, n, ak);
    chk("id_ack", {31'd0, ak}, 32'd1);
    chk("id_lat", n, 32'd1);
    chk("id_dat", rd, 32'h4653_4943);
    xfer(0, 32'h3000_0000, 4'hF, 0, rd, n, ak);
    chk("r0_rst", rd, 32'd0);

    xfer(1, 32'h3000_0004, 4'b0101,
         32'hA5A5_1234, rd, n, ak);
    chk("r1_wr_ack", {31'd0, ak}, 32'd1);
    xfer(0, 32'h3000_0004, 4'hF, 0, rd, n, ak);
    chk("r1_bytes", rd, 32'h00A5_0034);

    xfer(1, 32'h3000_0028, 4'hF, 32'd3, rd, n, ak);
    chk("wait3_wr_lat", n, 32'd1);
    xfer(0, 32'h3000_0000, 4'hF, 0, rd, n, ak);
    chk("wait3_lat", n, 32'd4);
    xfer(0, 32'h3000_0028, 4'hF, 0, rd, n, ak);
    chk("wait_rd", rd, 32'd3);
    xfer(1, 32'h3000_0028, 4'hF, 32'd0, rd, n, ak);
    chk("wait0_wr_lat", n, 32'd4);
    xfer(0, 32'h3000_0000, 4'hF, 0, rd, n, ak);
    chk("wait0_lat", n, 32'd1);

    xfer(1, 32'h3000_0028, 4'hF, 32'd5, rd, n, ak);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 32'h3000_0008;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_dat_i = 32'hDEAD_BEEF;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) seen++;
    end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) seen++;
    end
    chk("abort_noack", seen, 32'd0);
    xfer(1, 32'h3000_0028, 4'hF, 32'd0, rd, n, ak);
    chk("wait5_lat", n, 32'd6);
    xfer(0, 32'h3000_0008, 4'hF, 0, rd, n, ak);
    chk("abort_nowr", rd, 32'd0);

    xfer(0, 32'h3000_0024, 4'hF, 0, rd, n, ak);
    xfer(0, 32'h3000_0024, 4'hF, 0, rd2, n, ak);
    chk("cnt_delta", rd2 - rd, 32'd2);

    #1 force dut.cnt = 32'hFFFF_FFFD;
    #1 release dut.cnt;
    xfer(0, 32'h3000_0024, 4'hF, 0, rd, n, ak);
    chk("cnt_top", rd, 32'hFFFF_FFFE);
    xfer(0, 32'h3000_0024, 4'hF, 0, rd, n, ak);
    chk("cnt_wrap", rd, 32'd0);

    xfer(1, 32'h3000_0030, 4'hF, 32'h1234_5678, rd, n, ak);
    chk("unmap_wr_ack", {31'd0, ak}, 32'd1);
    xfer(0, 32'h3000_0030, 4'hF, 0, rd, n, ak);
    chk("unmap_rd", rd, 32'd0);
    xfer(1, 32'h3000_0020, 4'hF, 32'd0, rd, n, ak);
    chk("ro_wr_ack", {31'd0, ak}, 32'd1);
    xfer(0, 32'h3000_0020, 4'hF, 0, rd, n, ak);
    chk("ro_kept", rd, 32'h4653_4943);

    xfer(0, 32'h3000_0100, 4'hF, 0, rd, n, ak);
    chk("offwin_noack", {31'd0, ak}, 32'd0);

    xfer(1, 32'h3000_002C, 4'b0001,
         32'hFFFF_FFFF, rd, n, ak);
    chk("irq_set", {31'd0, irq}, 32'd1);
    xfer(0, 32'h3000_002C, 4'hF, 0, rd, n, ak);
    chk("irq_rd", rd, 32'd1);

    xfer(1, 32'h3000_0028, 4'hF, 32'd5, rd, n, ak);
    @(posedge clk); #1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = 1'b1;
    wb.wbs_adr_i = 32'h3000_000C;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_dat_i = 32'h1111_2222;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) seen++;
    end
    rstn = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) seen++;
    end
    chk("rst_mid_noack", seen, 32'd0);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    xfer(0, 32'h3000_000C, 4'hF, 0, rd, n, ak);
    chk("rst_mid_lat", n, 32'd1);
    chk("rst_mid_nowr", rd, 32'd0);
    xfer(0, 32'h3000_0004, 4'hF, 0, rd, n, ak);
    chk("rst_mid_r1", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
